// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types for the bus arbitration slice.
//   htrans_t    : transfer type encoding on htrans
//   hsize_t     : transfer size encoding on hsize
//   arb_state_t : master arbiter ownership state
package ahb_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    SizeByte   = 3'b000,
    SizeHalf   = 3'b001,
    SizeWord   = 3'b010,
    SizeDword  = 3'b011,
    Size4Word  = 3'b100,
    Size8Word  = 3'b101,
    Size16Word = 3'b110,
    Size32Word = 3'b111
  } hsize_t;

  typedef enum logic [1:0] {
    ArbPark,
    ArbGranted,
    ArbLocked
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   req_i   : request vector, one bit per requester
//   ptr_i   : index of the last winner; search starts at ptr_i + 1 and wraps
//   grant_o : one-hot winner (all zero when nothing requests)
//   valid_o : at least one request present
// The last-winner position is visited last, so it wins again only when alone.
module rr_picker #(
  parameter int unsigned N    = 3,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic            valid_o
);

  logic            found;
  logic [IdxW-1:0] cand;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IdxW'((32'(ptr_i) + i) % N);
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
      end
    end
  end

  assign valid_o = found;

endmodule

// File: rtl/ahb_master_arbiter.sv
// AHB-Lite multi-master arbiter: shares one slave-side fabric among masters.
//   i_hclk / i_hreset       : bus clock, asynchronous active-low reset
//   i_hbusreq / i_hlock     : per-master request and locked-sequence request
//   i_haddr_m .. i_hwdata_m : packed per-master address/control/write data
//   i_hready                : muxed slave ready from the decoder
//   o_hgrant / o_hmaster    : one-hot grant and address-phase owner index
//   o_data_master           : data-phase owner for read data / ready return
//   o_hmastlock             : current transfer is locked
//   o_haddr .. o_hwdata     : shared-bus signals steered from the owners
module ahb_master_arbiter import ahb_pkg::*; #(
  parameter int unsigned MASTER_COUNT   = 3,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned DEFAULT_MASTER = 0,
  localparam int unsigned MIDX_W        = $clog2(MASTER_COUNT)
) (
  input  logic                           i_hclk,
  input  logic                           i_hreset,
  input  logic [MASTER_COUNT-1:0]        i_hbusreq,
  input  logic [MASTER_COUNT-1:0]        i_hlock,
  input  logic [MASTER_COUNT*ADDR_WIDTH-1:0] i_haddr_m,
  input  logic [MASTER_COUNT*2-1:0]      i_htrans_m,
  input  logic [MASTER_COUNT-1:0]        i_hwrite_m,
  input  logic [MASTER_COUNT*3-1:0]      i_hsize_m,
  input  logic [MASTER_COUNT*DATA_WIDTH-1:0] i_hwdata_m,
  input  logic                           i_hready,
  output logic [MASTER_COUNT-1:0]        o_hgrant,
  output logic [MIDX_W-1:0]              o_hmaster,
  output logic [MIDX_W-1:0]              o_data_master,
  output logic                           o_hmastlock,
  output logic [ADDR_WIDTH-1:0]          o_haddr,
  output logic [1:0]                     o_htrans,
  output logic                           o_hwrite,
  output logic [2:0]                     o_hsize,
  output logic [DATA_WIDTH-1:0]          o_hwdata
);

  localparam logic [MIDX_W-1:0] DefIdx = MIDX_W'(DEFAULT_MASTER);

  arb_state_t        state_q, state_d;
  logic [MIDX_W-1:0] hmaster_q, hmaster_d;
  logic [MIDX_W-1:0] data_master_q;
  logic [MIDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic              hmastlock_q, hmastlock_d;

  logic [MASTER_COUNT-1:0] pick_grant;
  logic                    pick_valid;
  logic [MIDX_W-1:0]       pick_idx;
  logic                    pick_lock;

  logic [ADDR_WIDTH-1:0] own_addr;
  logic [1:0]            own_trans;
  logic                  own_write;
  logic [2:0]            own_size;
  logic                  own_req;
  logic                  own_lock;
  logic [DATA_WIDTH-1:0] dp_wdata;
  logic                  inhibit;

  rr_picker #(
    .N    (MASTER_COUNT),
    .IdxW (MIDX_W)
  ) u_rr_picker (
    .req_i   (i_hbusreq),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .valid_o (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned k = 0; k < MASTER_COUNT; k++) begin
      if (pick_grant[k]) pick_idx = MIDX_W'(k);
    end
  end

  assign pick_lock = |(pick_grant & i_hlock);

  // Owner slice select; unreachable indices fall back to the default master.
  always_comb begin
    own_addr  = i_haddr_m[DEFAULT_MASTER*ADDR_WIDTH +: ADDR_WIDTH];
    own_trans = i_htrans_m[DEFAULT_MASTER*2 +: 2];
    own_write = i_hwrite_m[DEFAULT_MASTER];
    own_size  = i_hsize_m[DEFAULT_MASTER*3 +: 3];
    own_req   = i_hbusreq[DEFAULT_MASTER];
    own_lock  = i_hlock[DEFAULT_MASTER];
    dp_wdata  = i_hwdata_m[DEFAULT_MASTER*DATA_WIDTH +: DATA_WIDTH];
    for (int unsigned k = 0; k < MASTER_COUNT; k++) begin
      if (hmaster_q == MIDX_W'(k)) begin
        own_addr  = i_haddr_m[k*ADDR_WIDTH +: ADDR_WIDTH];
        own_trans = i_htrans_m[k*2 +: 2];
        own_write = i_hwrite_m[k];
        own_size  = i_hsize_m[k*3 +: 3];
        own_req   = i_hbusreq[k];
        own_lock  = i_hlock[k];
      end
      if (data_master_q == MIDX_W'(k)) begin
        dp_wdata = i_hwdata_m[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A burst in progress (BUSY/SEQ) must not lose the address phase.
  assign inhibit = (own_trans == TransBusy) || (own_trans == TransSeq);

  always_ff @(posedge i_hclk or negedge i_hreset) begin
    if (!i_hreset) begin
      state_q       <= ArbPark;
      hmaster_q     <= DefIdx;
      data_master_q <= DefIdx;
      rr_ptr_q      <= DefIdx;
      hmastlock_q   <= 1'b0;
    end else if (i_hready) begin
      state_q       <= state_d;
      hmaster_q     <= hmaster_d;
      data_master_q <= hmaster_q;
      rr_ptr_q      <= rr_ptr_d;
      hmastlock_q   <= hmastlock_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hmaster_d = hmaster_q;
    rr_ptr_d  = rr_ptr_q;
    unique case (state_q)
      ArbPark: begin
        if (pick_valid) begin
          hmaster_d = pick_idx;
          rr_ptr_d  = pick_idx;
          state_d   = pick_lock ? ArbLocked : ArbGranted;
        end
      end
      ArbGranted: begin
        if (own_lock && own_req) begin
          state_d = ArbLocked;
        end else if (inhibit) begin
          state_d = ArbGranted;
        end else if (pick_valid) begin
          hmaster_d = pick_idx;
          rr_ptr_d  = pick_idx;
          state_d   = pick_lock ? ArbLocked : ArbGranted;
        end else begin
          hmaster_d = DefIdx;
          state_d   = ArbPark;
        end
      end
      ArbLocked: begin
        // Keep the grant one more cycle after hlock drops so the final
        // locked transfer completes before re-arbitration.
        if (!own_lock) state_d = ArbGranted;
      end
      default: begin
        hmaster_d = DefIdx;
        state_d   = ArbPark;
      end
    endcase

    hmastlock_d = 1'b0;
    for (int unsigned k = 0; k < MASTER_COUNT; k++) begin
      if (hmaster_d == MIDX_W'(k)) hmastlock_d = i_hlock[k] & i_hbusreq[k];
    end
  end

  always_comb begin
    o_hgrant = '0;
    for (int unsigned k = 0; k < MASTER_COUNT; k++) begin
      o_hgrant[k] = (hmaster_q == MIDX_W'(k));
    end
    o_hmaster     = hmaster_q;
    o_data_master = data_master_q;
    o_hmastlock   = hmastlock_q;
    o_haddr       = own_addr;
    o_htrans      = own_trans;
    o_hwrite      = own_write;
    o_hsize       = own_size;
    o_hwdata      = dp_wdata;
  end

endmodule
